uart_char_rx: RTL
=================

# uart_char_rx

UART receiver and character FIFO that turns the host serial line into the byte stream consumed by the UCI command parser (`char_in` / `char_in_valid` / `char_in_ready`). It oversamples the asynchronous RX pin, frames 8N1 characters, and buffers them in a small FIFO. The parser can then stall without losing host input while a move is executing. It sits between the top-level `uart_rx` pin and the UCI handler.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 16: number of FIFO entries. Must be a power of two, ≥ 2.

- `clk_in`  input  1  system clock
- `rst_in`  input  1  synchronous reset, active-low
- `rx_in`  input  1  asynchronous serial line; idle high
- `char_out`  output  8  FIFO head byte; 0 when FIFO is empty
- `char_out_valid`  output  1  FIFO non-empty
- `char_out_ready`  input  1  consumer accepts `char_out` this cycle
- `frame_err_out`  output  1  one-cycle pulse: stop bit sampled low
- `overflow_out`  output  1  one-cycle pulse: a good byte was dropped because the FIFO was full

## Operation
- `rx_in` passes through a 2-FF synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Bit timer: counter 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT). Bit index is 0..7.
- FSM states:
  - WAIT_IDLE (reset state). Go to IDLE once `rx_s`=1.
  - IDLE. Go to START when `rx_s`=0. Clear the timer.
  - START. Sample at timer = CLKS_PER_BIT/2 (integer division). If the sample is 0, clear the timer and go to DATA. If it is 1, treat it as a glitch and return to IDLE.
  - DATA. Sample each bit when the timer reaches CLKS_PER_BIT-1, i.e. mid-bit. Shift the bits in LSB first. After the 8th bit, go to STOP.
  - STOP. Sample at CLKS_PER_BIT-1. If the sample is 1, push the byte and go to IDLE. If it is 0, pulse `frame_err_out`, discard the byte, and go to WAIT_IDLE. This covers break and mis-sync.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow_out` pulses.
- Pop: occurs when `char_out_valid && char_out_ready`.
- FIFO implementation:
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits. Full/empty is determined from the MSB and the equal lower bits.
  - Pointers wrap naturally.
  - `char_out` is driven combinationally from the head entry, gated to 0 when empty.
- Simultaneous push and pop:
  - On an empty FIFO, no bypass: valid rises the next cycle.
  - On a full FIFO, both occur and the count is unchanged.
- A frame error never affects FIFO contents.

## Timing
- Reset (`rst_in`=0 at a clock edge):
  - FSM goes to WAIT_IDLE and the FIFO is emptied.
  - `char_out`=0, `char_out_valid`=0, `frame_err_out`=0, `overflow_out`=0.
  - Reset applied mid-frame abandons the frame. After release, no start bit is detected until `rx_s` has been seen high.
- Latency from the `rx_in` start edge to the stop-bit sample cycle: 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles.
- `char_out_valid` rises exactly 1 cycle after the stop-bit sample cycle.
- `frame_err_out` and `overflow_out` are registered and assert in the cycle after the stop-bit sample.
- Handshake:
  - `char_out` and `char_out_valid` are stable while `char_out_ready`=0.
  - At most one pop per cycle.
  - With `char_out_ready` tied to 1, each byte is visible for exactly 1 cycle.
- Sustained throughput: one byte per 10·CLKS_PER_BIT cycles. Back-to-back frames are supported, because the next start edge is detected in IDLE right after the stop-bit sample.

## Configuration
- `UART_RX_CR_FILTER_EN` defined: a received byte 0x0D is silently discarded at push time. There is no push, no overflow pulse, and no frame error unless the stop bit itself is bad. The UCI parser therefore sees only `\n` (0x0A) line endings from CRLF hosts.
- Not defined: every correctly framed byte, including 0x0D, is pushed.

## Test plan
Bench uses CLKS_PER_BIT=16 and FIFO_DEPTH=16.
- "go\n" sent back-to-back, ready=1 -> `char_out` = 0x67, 0x6F, 0x0A, each valid for 1 cycle, arriving 160 cycles apart. No error pulses.
- `rx_in` low for 4 cycles, then high -> no push, no `frame_err_out`. A following 0x41 frame is received correctly.
- 0x41 sent with stop bit 0, line then held low for 40 cycles -> one `frame_err_out` pulse, FIFO stays empty. A 0x42 frame sent after the line goes high -> 0x42 received.
- ready=0 while 17 bytes 0x00..0x10 are sent -> `overflow_out` pulses once, on the 17th byte. Setting ready=1 then drains exactly 0x00..0x0F in order, and valid drops after the 16th pop.
- FIFO full with ready=1 on the same cycle as the 17th stop-bit sample -> push accepted, no overflow, count stays 16.
- Bytes 0x0D, 0x0A sent -> with `UART_RX_CR_FILTER_EN`, only 0x0A appears. Without it, 0x0D then 0x0A appear.
- `rst_in`=0 for 1 cycle mid-DATA of 0x55, with 3 bytes already queued -> valid=0 next cycle. The remainder of the frame produces no byte and no error, and the next 0x33 frame is received.

Source files
------------

// File: rtl/uart_char_rx.sv
// rtl/uart_char_rx.sv - 8N1 UART receiver feeding a character FIFO for the UCI parser.
// Define UART_RX_CR_FILTER_EN to drop received 0x0D bytes at push time.
module uart_char_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_in,
    output logic [7:0] char_out,
    output logic       char_out_valid,
    input  logic       char_out_ready,
    output logic       frame_err_out,
    output logic       overflow_out
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    logic          rx_meta;
    logic          rx_s;
    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          stop_tick;
    logic          keep;
    logic          push_req;
    logic          push_ok;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && char_out_ready;

    assign char_out_valid = !empty;
    assign char_out       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

`ifdef UART_RX_CR_FILTER_EN
    assign keep = (shreg != 8'h0D);
`else
    assign keep = 1'b1;
`endif

    assign stop_tick = (state == STOP) && (timer == T_LAST);
    assign push_req  = stop_tick && rx_s && keep;
    // A full FIFO still accepts the byte when the head leaves on the same edge.
    assign push_ok   = push_req && (!full || pop);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state         <= WAIT_IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            frame_err_out <= 1'b0;
            overflow_out  <= 1'b0;
        end else begin
            frame_err_out <= 1'b0;
            overflow_out  <= push_req && full && !pop;
            case (state)
                WAIT_IDLE: begin
                    timer <= '0;
                    if (rx_s) state <= IDLE;
                end
                IDLE: begin
                    timer <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (timer == T_HALF) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer == T_LAST) begin
                        timer   <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            // Low stop bit means break or lost sync; wait for a real idle line.
                            frame_err_out <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
    end
endmodule
